// File: rtl/ppu_pkg.sv
// Shared PPU definitions: bus widths, VRAM read-owner codes, CPU access FSM encoding.
package ppu_pkg;

  localparam int unsigned PPU_ADDR_W = 14;
  localparam int unsigned PPU_DATA_W = 8;

  typedef enum logic {
    OWN_REND = 1'b0,
    OWN_CPU  = 1'b1
  } owner_t;

  // Issue is taken on the transition out of IDLE/PEND, so it is not a resting state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_WAIT = 2'd2
  } cpu_state_t;

  typedef struct packed {
    logic   vld;
    owner_t own;
  } tag_t;

endpackage

// File: rtl/ppu_vram_tag_pipe.sv
// Latency-matched {valid, owner} shift register; its exit says who owns vram_d_in this cycle.
module ppu_vram_tag_pipe
  import ppu_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output logic rend_hit_c,
  output logic cpu_hit_c
);

  tag_t [RD_LAT-1:0] pipe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= tag_in;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rend_hit_c = pipe_q[RD_LAT-1].vld && (pipe_q[RD_LAT-1].own == OWN_REND);
  assign cpu_hit_c  = pipe_q[RD_LAT-1].vld && (pipe_q[RD_LAT-1].own == OWN_CPU);

endmodule

// File: rtl/ppu_vram_arb.sv
// VRAM port arbiter: render fetches have fixed priority, CPU $2007 accesses use a one-deep buffer.
module ppu_vram_arb
  import ppu_pkg::*;
#(
  parameter int unsigned ADDR_W = PPU_ADDR_W,
  parameter int unsigned DATA_W = PPU_DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rend_req_in,
  input  logic [ADDR_W-1:0] rend_addr_in,
  output logic [DATA_W-1:0] rend_d_out,
  output logic              rend_vld_out,
  input  logic              ri_rd_req_in,
  input  logic              ri_wr_req_in,
  input  logic [ADDR_W-1:0] ri_addr_in,
  input  logic [DATA_W-1:0] ri_d_in,
  output logic [DATA_W-1:0] ri_d_out,
  output logic              ri_rd_done_out,
  output logic              ri_wr_done_out,
  output logic              ri_busy_out,
  output logic              ri_drop_out,
  output logic [ADDR_W-1:0] vram_addr_out,
  output logic [DATA_W-1:0] vram_d_out,
  output logic              vram_we_out,
  output logic              vram_re_out,
  input  logic [DATA_W-1:0] vram_d_in
);

  cpu_state_t        state, state_nxt;
  logic              buf_wr, buf_wr_nxt;
  logic [ADDR_W-1:0] buf_addr, buf_addr_nxt;
  logic [DATA_W-1:0] buf_data, buf_data_nxt;
  logic              cpu_issue, issue_wr, drop_c;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_data;
  logic              rend_hit, cpu_hit;
  tag_t              tag_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      buf_wr   <= 1'b0;
      buf_addr <= '0;
      buf_data <= '0;
    end else begin
      state    <= state_nxt;
      buf_wr   <= buf_wr_nxt;
      buf_addr <= buf_addr_nxt;
      buf_data <= buf_data_nxt;
    end
  end

  // A request seen on a free bus bypasses the buffer and issues at once.
  always_comb begin
    state_nxt    = state;
    buf_wr_nxt   = buf_wr;
    buf_addr_nxt = buf_addr;
    buf_data_nxt = buf_data;
    cpu_issue    = 1'b0;
    issue_wr     = buf_wr;
    issue_addr   = buf_addr;
    issue_data   = buf_data;
    drop_c       = ((ri_rd_req_in || ri_wr_req_in) && (state != ST_IDLE)) ||
                   (ri_rd_req_in && ri_wr_req_in);
    unique case (state)
      ST_IDLE: begin
        if (ri_rd_req_in || ri_wr_req_in) begin
          buf_wr_nxt   = ri_wr_req_in;
          buf_addr_nxt = ri_addr_in;
          buf_data_nxt = ri_d_in;
          issue_wr     = ri_wr_req_in;
          issue_addr   = ri_addr_in;
          issue_data   = ri_d_in;
          if (rend_req_in) begin
            state_nxt = ST_PEND;
          end else begin
            cpu_issue = 1'b1;
            state_nxt = ri_wr_req_in ? ST_IDLE : ST_WAIT;
          end
        end
      end
      ST_PEND: begin
        if (!rend_req_in) begin
          cpu_issue = 1'b1;
          state_nxt = buf_wr ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cpu_hit) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tag_c.vld = rend_req_in || (cpu_issue && !issue_wr);
    tag_c.own = rend_req_in ? OWN_REND : OWN_CPU;
  end

  ppu_vram_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .tag_in    (tag_c),
    .rend_hit_c(rend_hit),
    .cpu_hit_c (cpu_hit)
  );

  // Memory-side and owner-side output registers; address and write data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vram_addr_out  <= '0;
      vram_d_out     <= '0;
      vram_we_out    <= 1'b0;
      vram_re_out    <= 1'b0;
      ri_wr_done_out <= 1'b0;
      ri_drop_out    <= 1'b0;
      ri_busy_out    <= 1'b0;
      rend_vld_out   <= 1'b0;
      rend_d_out     <= '0;
      ri_rd_done_out <= 1'b0;
      ri_d_out       <= '0;
    end else begin
      if (rend_req_in) begin
        vram_re_out   <= 1'b1;
        vram_we_out   <= 1'b0;
        vram_addr_out <= rend_addr_in;
      end else if (cpu_issue) begin
        vram_re_out   <= !issue_wr;
        vram_we_out   <= issue_wr;
        vram_addr_out <= issue_addr;
        if (issue_wr) vram_d_out <= issue_data;
      end else begin
        vram_re_out <= 1'b0;
        vram_we_out <= 1'b0;
      end
      ri_wr_done_out <= cpu_issue && issue_wr;
      ri_drop_out    <= drop_c;
      ri_busy_out    <= (state_nxt != ST_IDLE);
      rend_vld_out   <= rend_hit;
      if (rend_hit) rend_d_out <= vram_d_in;
      ri_rd_done_out <= cpu_hit;
      if (cpu_hit) ri_d_out <= vram_d_in;
    end
  end

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Bench for ppu_vram_arb: directed timing checks on RD_LAT=1, random traffic on RD_LAT=1..4.
module tb_ppu_vram_arb;

  typedef struct packed {
    logic        wr;
    logic [13:0] a;
    logic [7:0]  d;
  } op_t;

  logic        clk;
  logic        rst;
  logic        rend_req;
  logic [13:0] rend_addr;
  logic        rd_req, wr_req;
  logic [13:0] ri_addr;
  logic [7:0]  ri_d;

  logic [7:0]  rend_d   [4];
  logic        rend_vld [4];
  logic [7:0]  ri_dout  [4];
  logic        rd_done  [4];
  logic        wr_done  [4];
  logic        busy     [4];
  logic        drop     [4];
  logic [13:0] vaddr    [4];
  logic [7:0]  vdout    [4];
  logic        vwe      [4];
  logic        vre      [4];
  logic [7:0]  vdin     [4];

  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 0;
  bit   sb_cpu = 0;
  int   req_cnt [4];
  int   vld_cnt [4];
  logic [7:0] rq [4][$];
  op_t  cq [4][$];

  // Memory contents: a fixed function of the address.
  function automatic logic [7:0] pat(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'hB9;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_lat
    logic [7:0] dly [4];

    ppu_vram_arb #(
      .RD_LAT(g + 1)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .rend_req_in   (rend_req),
      .rend_addr_in  (rend_addr),
      .rend_d_out    (rend_d[g]),
      .rend_vld_out  (rend_vld[g]),
      .ri_rd_req_in  (rd_req),
      .ri_wr_req_in  (wr_req),
      .ri_addr_in    (ri_addr),
      .ri_d_in       (ri_d),
      .ri_d_out      (ri_dout[g]),
      .ri_rd_done_out(rd_done[g]),
      .ri_wr_done_out(wr_done[g]),
      .ri_busy_out   (busy[g]),
      .ri_drop_out   (drop[g]),
      .vram_addr_out (vaddr[g]),
      .vram_d_out    (vdout[g]),
      .vram_we_out   (vwe[g]),
      .vram_re_out   (vre[g]),
      .vram_d_in     (vdin[g])
    );

    // Data is valid RD_LAT cycles after the cycle vram_re_out is high.
    always @(posedge clk) begin
      dly[0] <= pat(vaddr[g]);
      for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
    end

    if (g == 0) begin : g_async
      assign vdin[g] = pat(vaddr[g]);
    end else begin : g_dly
      assign vdin[g] = dly[g-1];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs(input int g);
    return 64'({rend_vld[g], rend_d[g], ri_dout[g], rd_done[g], wr_done[g], busy[g],
                drop[g], vaddr[g], vdout[g], vwe[g], vre[g]});
  endfunction

  // One clock: record render requests at the edge, check outputs at the falling edge.
  task automatic tick();
    op_t op;
    @(posedge clk);
    for (int g = 0; g < 4; g++) begin
      if (rst) begin
        rq[g].delete();
        cq[g].delete();
        req_cnt[g] = 0;
        vld_cnt[g] = 0;
      end else if (rend_req) begin
        rq[g].push_back(pat(rend_addr));
        req_cnt[g]++;
      end
    end
    @(negedge clk);
    if (mon_on) begin
      for (int g = 0; g < 4; g++) begin
        chk("we_re_excl", 64'(vwe[g] & vre[g]), 64'(0));
        chk("wr_done_eq_we", 64'(wr_done[g]), 64'(vwe[g]));
        if (rend_vld[g]) begin
          vld_cnt[g]++;
          chk("rend_q_nonempty", 64'(rq[g].size() != 0), 64'(1));
          if (rq[g].size() != 0) chk("rend_d", 64'(rend_d[g]), 64'(rq[g].pop_front()));
        end
        if (sb_cpu && vwe[g]) begin
          chk("cpu_wr_expected", 64'(cq[g].size() != 0 && cq[g][0].wr), 64'(1));
          if (cq[g].size() != 0 && cq[g][0].wr) begin
            op = cq[g].pop_front();
            chk("cpu_wr_addr", 64'(vaddr[g]), 64'(op.a));
            chk("cpu_wr_data", 64'(vdout[g]), 64'(op.d));
          end
        end
        if (sb_cpu && rd_done[g]) begin
          chk("cpu_rd_expected", 64'(cq[g].size() != 0 && !cq[g][0].wr), 64'(1));
          if (cq[g].size() != 0 && !cq[g][0].wr) begin
            op = cq[g].pop_front();
            chk("cpu_rd_data", 64'(ri_dout[g]), 64'(pat(op.a)));
          end
        end
      end
    end
  endtask

  initial begin
    int  run;
    bit  idle;
    op_t op;
    rst = 1'b1; rend_req = 1'b0; rend_addr = '0;
    rd_req = 1'b0; wr_req = 1'b0; ri_addr = '0; ri_d = '0;

    tick(); tick();
    for (int g = 0; g < 4; g++) chk("reset_outs", outs(g), 64'(0));
    rst = 1'b0;
    mon_on = 1'b1;

    // CPU write on an idle bus.
    wr_req = 1'b1; ri_addr = 14'h2005; ri_d = 8'hA5;
    tick();
    wr_req = 1'b0;
    chk("wr_we", 64'(vwe[0]), 64'(1));
    chk("wr_re", 64'(vre[0]), 64'(0));
    chk("wr_addr", 64'(vaddr[0]), 64'h2005);
    chk("wr_data", 64'(vdout[0]), 64'hA5);
    chk("wr_done", 64'(wr_done[0]), 64'(1));
    tick();
    chk("wr_we_off", 64'(vwe[0]), 64'(0));
    chk("wr_addr_hold", 64'(vaddr[0]), 64'h2005);
    chk("wr_busy_off", 64'(busy[0]), 64'(0));

    // CPU read, RD_LAT=1: done two cycles after the request.
    rd_req = 1'b1; ri_addr = 14'h23C0;
    tick();
    rd_req = 1'b0;
    chk("rd_re", 64'(vre[0]), 64'(1));
    chk("rd_addr", 64'(vaddr[0]), 64'h23C0);
    chk("rd_busy", 64'(busy[0]), 64'(1));
    chk("rd_done_early", 64'(rd_done[0]), 64'(0));
    tick();
    chk("rd_done", 64'(rd_done[0]), 64'(1));
    chk("rd_data", 64'(ri_dout[0]), 64'h5A);
    chk("rd_busy_off", 64'(busy[0]), 64'(0));
    tick();
    chk("rd_done_pulse", 64'(rd_done[0]), 64'(0));
    repeat (4) tick();

    // Contention: seven render reads hold off a CPU read until cycle 8.
    rend_req = 1'b1; rend_addr = 14'h0100; rd_req = 1'b1; ri_addr = 14'h3F00;
    tick();
    rd_req = 1'b0;
    chk("cont_re0", 64'(vre[0]), 64'(1));
    chk("cont_addr0", 64'(vaddr[0]), 64'h0100);
    chk("cont_busy", 64'(busy[0]), 64'(1));
    for (int k = 1; k < 7; k++) begin
      rend_addr = 14'(14'h0100 + k);
      tick();
      chk("cont_rend_addr", 64'(vaddr[0]), 64'(14'h0100 + k));
      chk("cont_cpu_wait", 64'(rd_done[0]), 64'(0));
    end
    rend_req = 1'b0;
    tick();
    chk("cont_cpu_re", 64'(vre[0]), 64'(1));
    chk("cont_cpu_addr", 64'(vaddr[0]), 64'h3F00);
    tick();
    chk("cont_cpu_done", 64'(rd_done[0]), 64'(1));
    chk("cont_cpu_data", 64'(ri_dout[0]), 64'h86);
    repeat (6) tick();

    // Drop while in WAIT, then accept a write in the rd_done cycle.
    rd_req = 1'b1; ri_addr = 14'h0040;
    tick();
    ri_addr = 14'h0041;
    tick();
    rd_req = 1'b0;
    chk("drop_pulse", 64'(drop[0]), 64'(1));
    chk("drop_no_issue", 64'(vre[0]), 64'(0));
    chk("drop_first_done", 64'(rd_done[0]), 64'(1));
    chk("drop_first_data", 64'(ri_dout[0]), 64'hF9);
    wr_req = 1'b1; ri_addr = 14'h0042; ri_d = 8'h3C;
    tick();
    wr_req = 1'b0;
    chk("accept_on_done_we", 64'(vwe[0]), 64'(1));
    chk("accept_on_done_addr", 64'(vaddr[0]), 64'h0042);
    chk("accept_on_done_data", 64'(vdout[0]), 64'h3C);
    chk("accept_on_done_drop", 64'(drop[0]), 64'(0));
    repeat (6) tick();

    // Simultaneous read and write: only the write is issued.
    rd_req = 1'b1; wr_req = 1'b1; ri_addr = 14'h1234; ri_d = 8'h77;
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    chk("both_we", 64'(vwe[0]), 64'(1));
    chk("both_re", 64'(vre[0]), 64'(0));
    chk("both_addr", 64'(vaddr[0]), 64'h1234);
    chk("both_data", 64'(vdout[0]), 64'h77);
    chk("both_drop", 64'(drop[0]), 64'(1));
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("both_no_read", 64'(rd_done[0]), 64'(0));
      chk("both_idle", 64'(busy[0]), 64'(0));
    end

    // Reset during a read in flight.
    rd_req = 1'b1; ri_addr = 14'h0050;
    tick();
    rd_req = 1'b0; rst = 1'b1;
    tick(); tick();
    for (int g = 0; g < 4; g++) chk("midrd_reset_outs", outs(g), 64'(0));
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int g = 0; g < 4; g++) begin
        chk("midrd_no_done", 64'(rd_done[g]), 64'(0));
        chk("midrd_not_busy", 64'(busy[g]), 64'(0));
      end
    end

    // Random render and CPU traffic on all latencies.
    sb_cpu = 1'b1;
    run = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rend_req = (run < 7) && ($urandom_range(0, 3) != 0);
      run = rend_req ? run + 1 : 0;
      rend_addr = 14'($urandom);
      rd_req = 1'b0; wr_req = 1'b0;
      idle = 1'b1;
      for (int g = 0; g < 4; g++) if (cq[g].size() != 0) idle = 1'b0;
      if (idle && $urandom_range(0, 4) == 0) begin
        op.wr = 1'($urandom_range(0, 1));
        op.a  = 14'($urandom);
        op.d  = 8'($urandom);
        wr_req = op.wr; rd_req = !op.wr; ri_addr = op.a; ri_d = op.d;
        for (int g = 0; g < 4; g++) cq[g].push_back(op);
      end
      tick();
    end
    rend_req = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    repeat (20) tick();
    for (int g = 0; g < 4; g++) begin
      chk("rend_vld_count", 64'(vld_cnt[g]), 64'(req_cnt[g]));
      chk("cpu_all_done", 64'(cq[g].size()), 64'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
